// File: rtl/sr_ff_test_driver.sv
// Purpose: drives S/R of an SR flip-flop from a fixed 6-step vector table, checks Q/Qbar against a reference.
// Latency: (SETTLE_CYCLES+2) cycles per step; 6*(SETTLE_CYCLES+2)*NUM_PASSES + 1 cycles from start-accept to o_Done.
// Backpressure: none; i_Start is accepted only in IDLE and ignored while a run is busy or finishing.
module sr_ff_test_driver #(
  parameter int SETTLE_CYCLES = 1,   // 1..15
  parameter int NUM_PASSES    = 1,   // 1..255
  parameter int ERR_W         = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  output logic             o_S,
  output logic             o_R,
  input  logic             i_Q,
  input  logic             i_Qbar,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Pass,
  output logic [ERR_W-1:0] o_Err_Count,
  output logic [2:0]       o_Fail_Step
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [2:0]       NO_FAIL   = 3'd7;
  localparam logic [2:0]       LAST_STEP = 3'd5;
  localparam logic [7:0]       LAST_PASS = 8'(NUM_PASSES - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state, state_nxt;
  logic [3:0]       settle_cnt;
  logic [2:0]       step;
  logic [7:0]       pass_idx;
  logic             tbl_s, tbl_r, tbl_q, tbl_chk;
  logic             mismatch;
  logic             last_step, last_pass;
  logic [ERR_W-1:0] err_nxt;

  // Vector table: S/R drive per step, expected Q, and whether the step is checked.
  // Step 5 drives both S and R, so Q is undefined afterwards; each pass restarts at step 0 to recover.
  always_comb begin
    tbl_s   = 1'b0;
    tbl_r   = 1'b0;
    tbl_q   = 1'b0;
    tbl_chk = 1'b0;
    case (step)
      3'd0: begin tbl_s = 1'b0; tbl_r = 1'b1; tbl_q = 1'b0; tbl_chk = 1'b1; end
      3'd1: begin tbl_s = 1'b0; tbl_r = 1'b0; tbl_q = 1'b0; tbl_chk = 1'b1; end
      3'd2: begin tbl_s = 1'b1; tbl_r = 1'b0; tbl_q = 1'b1; tbl_chk = 1'b1; end
      3'd3: begin tbl_s = 1'b0; tbl_r = 1'b0; tbl_q = 1'b1; tbl_chk = 1'b1; end
      3'd4: begin tbl_s = 1'b0; tbl_r = 1'b1; tbl_q = 1'b0; tbl_chk = 1'b1; end
      3'd5: begin tbl_s = 1'b1; tbl_r = 1'b1; tbl_q = 1'b0; tbl_chk = 1'b0; end
      default: ;
    endcase
  end

  // Wrong Q and non-complementary Qbar in the same step count as a single error.
  always_comb begin
    mismatch  = tbl_chk && ((i_Q != tbl_q) || (i_Qbar == i_Q));
    last_step = (step == LAST_STEP);
    last_pass = (pass_idx == LAST_PASS);
    err_nxt   = o_Err_Count;
    if (state == CHECK && mismatch && o_Err_Count != ERR_MAX) begin
      err_nxt = o_Err_Count + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_nxt = CHECK;
      CHECK:   state_nxt = (last_step && last_pass) ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered drive, step/pass sequencing, error bookkeeping and result outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_S         <= 1'b0;
      o_R         <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Pass      <= 1'b0;
      o_Err_Count <= '0;
      o_Fail_Step <= NO_FAIL;
      settle_cnt  <= 4'd0;
      step        <= 3'd0;
      pass_idx    <= 8'd0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_S <= 1'b0;
          o_R <= 1'b0;
          if (i_Start) begin
            o_Busy      <= 1'b1;
            o_Pass      <= 1'b0;
            o_Err_Count <= '0;
            o_Fail_Step <= NO_FAIL;
            step        <= 3'd0;
            pass_idx    <= 8'd0;
          end
        end
        DRIVE: begin
          o_S        <= tbl_s;
          o_R        <= tbl_r;
          settle_cnt <= SETTLE_LD;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          o_Err_Count <= err_nxt;
          if (mismatch && o_Fail_Step == NO_FAIL) o_Fail_Step <= step;
          if (!last_step) begin
            step <= step + 3'd1;
          end else if (!last_pass) begin
            step     <= 3'd0;
            pass_idx <= pass_idx + 8'd1;
          end else begin
            // Leaving for FINISH: release the flip-flop and publish the result.
            o_S    <= 1'b0;
            o_R    <= 1'b0;
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
            o_Pass <= (err_nxt == '0);
          end
        end
        FINISH: begin
          o_S <= 1'b0;
          o_R <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sr_ff_test_driver.md
Name: sr_ff_test_driver

Overview:
- Self-test initiator for the SR flip-flop: drives the S/R inputs of a flip-flop under test from a fixed vector sequence.
- Samples Q/Qbar back, compares against an internal SR reference model, and reports pass/fail with an error count and the first failing step.
- Sits beside the flip-flop in hardware as the driving and checking end of its S/R -> Q/Qbar interface.
- Replaces a simulation-only stimulus bench.

Parameters:
- SETTLE_CYCLES, 1, clocks to wait after driving a vector before sampling Q/Qbar (range 1..15).
- NUM_PASSES, 1, number of times the full vector sequence is repeated per start (range 1..255).
- ERR_W, 8, width of the error counter.

Ports:
- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Start  input  1  single-cycle start pulse; ignored unless idle.
- o_S  output  1  Set drive to flip-flop under test (registered).
- o_R  output  1  Reset drive to flip-flop under test (registered).
- i_Q  input  1  Q from flip-flop under test.
- i_Qbar  input  1  Qbar from flip-flop under test.
- o_Busy  output  1  high from the cycle after accepted start until done.
- o_Done  output  1  single-cycle pulse when all passes complete.
- o_Pass  output  1  valid when o_Done is high or later: 1 = zero errors; holds until next start.
- o_Err_Count  output  ERR_W  mismatches in the current/last run; saturates at all-ones.
- o_Fail_Step  output  3  step index of the first mismatch; 7 = no failure.

Behaviour:
- Reset (async assert, sync-safe release): o_S=0, o_R=0, o_Busy=0, o_Done=0, o_Pass=0, o_Err_Count=0, o_Fail_Step=7, FSM=IDLE.
- Vector table, step index 0..5 as (S,R) -> expected Q:
  - step 0: (0,1) -> 0
  - step 1: (0,0) -> 0
  - step 2: (1,0) -> 1
  - step 3: (0,0) -> 1
  - step 4: (0,1) -> 0
  - step 5: (1,1) -> no check
- Check rule for steps 0..4: mismatch if i_Q != expected OR i_Qbar != ~i_Q (both conditions counted as a single error).
- FSM states:
  - IDLE: o_S=o_R=0. On i_Start: clear counters, o_Fail_Step=7, o_Pass=0, step=0, pass=0 -> DRIVE.
  - DRIVE: register o_S/o_R from table[step]; load settle counter = SETTLE_CYCLES -> SETTLE.
  - SETTLE: decrement each cycle; at 0 -> CHECK.
  - CHECK: sample i_Q/i_Qbar, apply check rule.
    - On mismatch: o_Err_Count++ (saturating); if o_Fail_Step==7, latch step.
    - Then if step<5: step++ -> DRIVE.
    - Else if pass<NUM_PASSES-1: pass++, step=0 -> DRIVE.
    - Else -> FINISH.
  - FINISH: o_S=o_R=0, o_Done=1 for one cycle, o_Pass=(o_Err_Count==0), o_Busy=0 -> IDLE.
- Latency per step: 1 (DRIVE) + SETTLE_CYCLES + 1 (CHECK) cycles. With SETTLE_CYCLES=1, o_S/o_R are stable for 3 cycles per step.
  - Full run: 6*(SETTLE_CYCLES+2)*NUM_PASSES cycles, plus 1 FINISH cycle, from the start-accept cycle.
- Each new pass starts with step 0 (reset vector), so the reference model is always known again after the unchecked step 5.
- i_Start while busy: ignored; no restart, counters untouched.
- i_Start in the same cycle as the o_Done pulse: ignored (FSM is in FINISH). Accepted from the next cycle.
- Async reset mid-run: all outputs immediately return to reset values, including o_S/o_R=0. The run is lost and no o_Done is produced.
- i_Q/i_Qbar are sampled only in CHECK; other cycles are don't-care.

Test Plan:
- Reset then start, with a correct SR flip-flop attached, SETTLE_CYCLES=1, NUM_PASSES=1 -> o_S/o_R follow 01,00,10,00,01,11 at 3-cycle spacing; o_Done pulses 19 cycles after start-accept; o_Pass=1, o_Err_Count=0, o_Fail_Step=7.
- Flip-flop with Q stuck at 0 -> mismatches at steps 2 and 3; o_Err_Count=2, o_Fail_Step=2, o_Pass=0.
- Flip-flop with Qbar tied equal to Q -> checked steps 0..4 all fail; o_Err_Count=5, o_Fail_Step=0; step 5 not counted.
- NUM_PASSES=3, ERR_W=2, stuck-at-0 flip-flop -> 6 raw errors, o_Err_Count saturates at 3, o_Fail_Step=2; o_Done after 3*18+1 cycles.
- i_Start pulsed at step 3, then i_Rst_L low for 1 cycle at step 4 -> extra start has no effect; on reset all outputs read reset values immediately, o_Done never pulses. A fresh start completes normally with o_Pass=1.
- Start pulse on the o_Done cycle -> ignored, o_Busy stays 0. Start one cycle later -> accepted, o_Pass clears to 0 until the new o_Done.
